dma_line_writer: RTL and testbench

//  Avalon-MM burst write master: the initiator that consumes the DMA base address register.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_wr_fifo.sv | 63 ++++++
 rtl/dma_line_writer.sv | 191 +++++++++++++++++++
 tb/tb_dma_line_writer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA line writer.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        BURST     = 2'd2,
        FINISH    = 2'd3
    } dma_state_e;

    // Bytes per word at the default 32-bit data width.
    localparam int unsigned BPW = 4;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dma_wr_fifo.sv
// Show-ahead FIFO buffering sink words ahead of the Avalon-MM bursts.
// dout always presents the head entry; pop advances it on the next edge.
module dma_wr_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/dma_line_writer.sv
// Avalon-MM burst write master: moves one scan line from an Avalon-ST sink
// into memory at the programmed base address, one line per start pulse.
module dma_line_writer
    import dma_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 28,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned LINE_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_W-1:0]            dma_address,
    input  logic                         start,
    input  logic [DATA_W-1:0]            snk_data,
    input  logic                         snk_valid,
    output logic                         snk_ready,
    output logic [ADDR_W-1:0]            avm_address,
    output logic                         avm_write,
    output logic [DATA_W-1:0]            avm_writedata,
    output logic [DATA_W/8-1:0]          avm_byteenable,
    output logic [$clog2(BURST_LEN):0]   avm_burstcount,
    input  logic                         avm_waitrequest,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned WORD_BYTES = bytes_per_word(DATA_W);
    localparam int unsigned BC_W       = $clog2(BURST_LEN) + 1;
    localparam int unsigned REM_W      = $clog2(LINE_WORDS + 1);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    // Reset asserts asynchronously and releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    dma_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [REM_W-1:0]  remain_q, remain_d;
    logic [BC_W-1:0]   beat_q, beat_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic [BC_W-1:0]   blen_c;
    logic              fifo_ready_c;
    logic              beat_c;
    logic              last_beat_c;

    assign snk_ready = busy_q && !fifo_full;
    assign fifo_push = snk_valid && snk_ready;
    assign fifo_pop  = beat_c;

    dma_wr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (snk_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Burst length: a full burst, or whatever is left of the line.
    always_comb begin
        if (32'(remain_q) >= BURST_LEN) begin
            blen_c = BC_W'(BURST_LEN);
        end else begin
            blen_c = BC_W'(remain_q);
        end
    end

    assign fifo_ready_c = (32'(fifo_count) >= 32'(blen_c));
    assign beat_c       = write_q && !avm_waitrequest;
    assign last_beat_c  = beat_c && (beat_q == (bcnt_q - BC_W'(1)));

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        write_d     = write_q;
        addr_d      = addr_q;
        bcnt_d      = bcnt_q;
        next_addr_d = next_addr_q;
        remain_d    = remain_q;
        beat_d      = beat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    next_addr_d = dma_address;
                    remain_d    = REM_W'(LINE_WORDS);
                    busy_d      = 1'b1;
                    state_d     = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                // Address and burstcount are frozen here for the whole burst.
                if (fifo_ready_c) begin
                    addr_d      = next_addr_q;
                    bcnt_d      = blen_c;
                    next_addr_d = next_addr_q + ADDR_W'(32'(blen_c) * WORD_BYTES);
                    beat_d      = '0;
                    write_d     = 1'b1;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (beat_c) begin
                    beat_d = beat_q + BC_W'(1);
                    if (last_beat_c) begin
                        write_d  = 1'b0;
                        remain_d = remain_q - REM_W'(bcnt_q);
                        if (remain_q == REM_W'(bcnt_q)) begin
                            done_d  = 1'b1;
                            state_d = FINISH;
                        end else begin
                            state_d = WAIT_DATA;
                        end
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            bcnt_q      <= '0;
            next_addr_q <= '0;
            remain_q    <= '0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            bcnt_q      <= bcnt_d;
            next_addr_q <= next_addr_d;
            remain_q    <= remain_d;
            beat_q      <= beat_d;
        end
    end

    // Write data is forced to zero outside a burst so stale FIFO contents never leak.
    assign avm_writedata  = (write_q && !fifo_empty) ? fifo_dout : '0;
    assign avm_address    = addr_q;
    assign avm_write      = write_q;
    assign avm_burstcount = bcnt_q;
    assign avm_byteenable = '1;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_dma_line_writer.sv
// Directed bench for dma_line_writer: line transfers from a vector table plus
// hand sequences for idle offers, FIFO back-pressure and reset mid-burst.
module tb_dma_line_writer;

    localparam int unsigned LINE  = 20;
    localparam int unsigned BLEN  = 8;
    localparam int unsigned RECN  = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [27:0] dma_address;
    logic        start;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic [27:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [3:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    dma_line_writer #(
        .DATA_W     (32),
        .ADDR_W     (28),
        .BURST_LEN  (BLEN),
        .LINE_WORDS (LINE),
        .FIFO_DEPTH (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .dma_address     (dma_address),
        .start           (start),
        .snk_data        (snk_data),
        .snk_valid       (snk_valid),
        .snk_ready       (snk_ready),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_burstcount  (avm_burstcount),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done)
    );

    typedef struct {
        logic [27:0] base;
        logic [31:0] seed;
        int          pct;
        int          mid_at;
        logic [27:0] mid_addr;
        logic [27:0] exp_b0;
        logic [27:0] exp_b1;
        logic [27:0] exp_b2;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [27:0] rec_addr [RECN];
    logic [31:0] rec_data [RECN];
    logic [3:0]  rec_bc   [RECN];
    int          n_beats;
    int          done_cnt;
    int          feed_left;
    logic [31:0] feed_val;
    int          stall_pct;
    bit          force_stall;
    bit          prev_stall;
    logic [27:0] prev_addr;
    logic [31:0] prev_data;
    logic [3:0]  prev_bc;
    bit          gap_next;
    int          burst_beat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, observe, then cross the rising edge.
    task automatic cycle();
        logic pushed;
        avm_waitrequest = force_stall || (stall_pct > 0 && int'($urandom_range(99)) < stall_pct);
        snk_valid = (feed_left > 0);
        snk_data  = feed_val;
        #1;
        if (done) done_cnt++;
        if (gap_next) chk("gap_write_low", 32'(avm_write), 32'd0);
        gap_next = 1'b0;
        if (prev_stall) begin
            chk("stall_write", 32'(avm_write), 32'd1);
            chk("stall_addr", 32'(avm_address), 32'(prev_addr));
            chk("stall_data", avm_writedata, prev_data);
            chk("stall_bc", 32'(avm_burstcount), 32'(prev_bc));
        end
        pushed = snk_valid && snk_ready;
        if (avm_write && !avm_waitrequest) begin
            if (n_beats < int'(RECN)) begin
                rec_addr[n_beats] = avm_address + 28'(burst_beat * 4);
                rec_data[n_beats] = avm_writedata;
                rec_bc[n_beats]   = avm_burstcount;
            end
            n_beats++;
            burst_beat++;
            if (burst_beat == int'(avm_burstcount)) begin
                burst_beat = 0;
                gap_next   = 1'b1;
            end
        end
        prev_stall = avm_write && avm_waitrequest;
        prev_addr  = avm_address;
        prev_data  = avm_writedata;
        prev_bc    = avm_burstcount;
        @(posedge clk);
        if (pushed) begin
            feed_left--;
            feed_val++;
        end
        @(negedge clk);
    endtask

    task automatic start_line(input logic [27:0] base, input logic [31:0] seed, input int pct);
        for (int i = 0; i < int'(RECN); i++) begin
            rec_addr[i] = '0;
            rec_data[i] = '0;
            rec_bc[i]   = '0;
        end
        n_beats     = 0;
        done_cnt    = 0;
        burst_beat  = 0;
        gap_next    = 1'b0;
        prev_stall  = 1'b0;
        force_stall = 1'b0;
        feed_left   = LINE;
        feed_val    = seed;
        stall_pct   = pct;
        dma_address = base;
        start       = 1'b1;
        cycle();
        start       = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic check_line(input vec_t v);
        logic [27:0] exp_a;
        chk("line_done_timeout", 32'(done_cnt > 0), 32'd1);
        repeat (4) cycle();
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("beat_total", 32'(n_beats), 32'(LINE));
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("feed_drained", 32'(feed_left), 32'd0);
        for (int i = 0; i < int'(LINE); i++) begin
            exp_a = v.base + 28'(i * 4);
            chk($sformatf("data[%0d]", i), rec_data[i], v.seed + 32'(i));
            chk($sformatf("addr[%0d]", i), 32'(rec_addr[i]), 32'(exp_a));
            chk($sformatf("bcount[%0d]", i), 32'(rec_bc[i]), (i < 16) ? 32'd8 : 32'd4);
        end
        chk("burst0_addr", 32'(rec_addr[0]), 32'(v.exp_b0));
        chk("burst1_addr", 32'(rec_addr[8]), 32'(v.exp_b1));
        chk("burst2_addr", 32'(rec_addr[16]), 32'(v.exp_b2));
    endtask

    task automatic wait_done(input vec_t v);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            if (cyc == v.mid_at) begin
                start       = 1'b1;
                dma_address = v.mid_addr;
            end
            cycle();
            start = 1'b0;
            cyc++;
        end
    endtask

    vec_t vecs [5];
    vec_t vfull;
    vec_t vrst;

    initial begin
        vecs[0] = '{28'h0100000, 32'h0000_0000,  0, -1, 28'h0,       28'h0100000, 28'h0100020, 28'h0100040};
        vecs[1] = '{28'h0200000, 32'h0000_0100, 50, -1, 28'h0,       28'h0200000, 28'h0200020, 28'h0200040};
        vecs[2] = '{28'hFFFFFF0, 32'h0000_0200,  0, -1, 28'h0,       28'hFFFFFF0, 28'h0000010, 28'h0000030};
        vecs[3] = '{28'h0300000, 32'h0000_0300,  0, 10, 28'h0700000, 28'h0300000, 28'h0300020, 28'h0300040};
        vecs[4] = '{28'h0700000, 32'h0000_0400, 25, -1, 28'h0,       28'h0700000, 28'h0700020, 28'h0700040};
        vfull   = '{28'h0500000, 32'h0000_0500,  0, -1, 28'h0,       28'h0500000, 28'h0500020, 28'h0500040};
        vrst    = '{28'h0600000, 32'h0000_0700,  0, -1, 28'h0,       28'h0600000, 28'h0600020, 28'h0600040};

        reset_n         = 1'b0;
        dma_address     = '0;
        start           = 1'b0;
        snk_data        = '0;
        snk_valid       = 1'b0;
        avm_waitrequest = 1'b0;
        force_stall     = 1'b0;
        stall_pct       = 0;
        feed_left       = 0;
        feed_val        = '0;
        n_beats         = 0;
        done_cnt        = 0;
        prev_stall      = 1'b0;
        gap_next        = 1'b0;
        burst_beat      = 0;
        repeat (3) @(negedge clk);

        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_snk_ready", 32'(snk_ready), 32'd0);
        chk("rst_address", 32'(avm_address), 32'd0);
        chk("rst_burstcount", 32'(avm_burstcount), 32'd0);
        chk("rst_writedata", avm_writedata, 32'd0);
        chk("rst_byteenable", 32'(avm_byteenable), 32'hF);

        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Words offered while idle must be refused.
        snk_valid = 1'b1;
        snk_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_snk_ready", 32'(snk_ready), 32'd0);
            @(negedge clk);
        end
        snk_valid = 1'b0;

        for (int k = 0; k < 5; k++) begin
            start_line(vecs[k].base, vecs[k].seed, vecs[k].pct);
            wait_done(vecs[k]);
            check_line(vecs[k]);
        end

        // Slave stalls the first burst long enough for the FIFO to fill.
        start_line(vfull.base, vfull.seed, 0);
        force_stall = 1'b1;
        repeat (40) cycle();
        chk("full_snk_ready", 32'(snk_ready), 32'd0);
        chk("full_write_held", 32'(avm_write), 32'd1);
        chk("full_no_beats", 32'(n_beats), 32'd0);
        chk("full_words_taken", 32'(feed_left), 32'(LINE - 16));
        chk("full_head_data", avm_writedata, vfull.seed);
        chk("full_addr", 32'(avm_address), 32'(vfull.base));
        force_stall = 1'b0;
        wait_done(vfull);
        check_line(vfull);

        // Reset while the third beat of the first burst is on the bus.
        start_line(28'h0ABC000, 32'h0000_0600, 0);
        for (int i = 0; i < 200 && n_beats < 2; i++) cycle();
        chk("abort_pre_write", 32'(avm_write), 32'd1);
        chk("abort_pre_beats", 32'(n_beats), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("abort_write", 32'(avm_write), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_snk_ready", 32'(snk_ready), 32'd0);
        feed_left = 0;
        snk_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        done_cnt = 0;
        prev_stall = 1'b0;
        gap_next   = 1'b0;
        repeat (6) cycle();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);

        start_line(vrst.base, vrst.seed, 0);
        wait_done(vrst);
        check_line(vrst);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
